// File: rtl/scope_pkg.sv
// Shared types for the scope capture block: FSM encoding and trigger slope codes.
package scope_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRETRIG  = 3'd1,
    ARMED    = 3'd2,
    POSTTRIG = 3'd3,
    READOUT  = 3'd4
  } state_t;

  localparam logic SLOPE_RISING  = 1'b0;
  localparam logic SLOPE_FALLING = 1'b1;

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port sample buffer: one write port, registered read (1-cycle latency).
module scope_capture_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/scope_capture_trigger.sv
// Edge-triggered capture into a circular buffer with programmable pre-trigger depth,
// followed by an in-order valid/ready readout of the full buffer.
module scope_capture_trigger
  import scope_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pretrig_len,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  localparam int DEPTH = 2**ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr, fill_cnt, rd_ptr, rd_ptr_nxt, rd_cnt, trig_addr, pre_len;
  logic [ADDR_W:0]   post_cnt, post_target;
  logic [DATA_W-1:0] lvl, prev, ram_q;
  logic              slope, prev_valid, accept, we, edge_hit, trig_hit, post_done;
  logic              to_readout, xfer;

  assign accept      = sample_valid && (state == PRETRIG || state == ARMED || state == POSTTRIG);
  assign post_target = (ADDR_W+1)'(DEPTH) - {1'b0, pre_len};
  assign post_done   = (post_cnt == post_target);
  // The final POSTTRIG cycle only hands over to readout; nothing is written then.
  assign we          = accept && !(state == POSTTRIG && post_done);

  assign edge_hit = prev_valid && ((slope == SLOPE_RISING)
                    ? (prev < lvl && sample_data >= lvl)
                    : (prev > lvl && sample_data <= lvl));
  assign trig_hit = (state == ARMED) && sample_valid && (force_trig || edge_hit);

  assign to_readout = !abort && (state == POSTTRIG) &&
                      (post_done || (sample_valid && (post_cnt + 1'b1) == post_target));
  assign xfer       = rd_valid && rd_ready;

  // Read address runs one step ahead so ram_q always mirrors mem[rd_ptr]:
  // data holds while stalled and advances with no bubble on each transfer.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (to_readout) rd_ptr_nxt = trig_addr - pre_len;
    else if (xfer)  rd_ptr_nxt = rd_ptr + 1'b1;
  end

  assign rd_data = rd_valid ? ram_q : '0;
  assign rd_last = rd_valid && (rd_cnt == ADDR_W'(DEPTH-1));
  assign done    = xfer && rd_last && !abort;
  assign busy    = (state != IDLE);

  scope_capture_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (sample_data),
    .raddr (rd_ptr_nxt),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      rd_ptr     <= '0;
      rd_cnt     <= '0;
      trig_addr  <= '0;
      pre_len    <= '0;
      lvl        <= '0;
      slope      <= 1'b0;
      prev       <= '0;
      prev_valid <= 1'b0;
      triggered  <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (accept) begin
        prev       <= sample_data;
        prev_valid <= 1'b1;
      end
      if (we) wr_ptr <= wr_ptr + 1'b1;

      if (abort) begin
        state     <= IDLE;
        rd_valid  <= 1'b0;
        triggered <= 1'b0;
      end else begin
        case (state)
          IDLE: if (arm) begin
            state      <= PRETRIG;
            lvl        <= trig_level;
            slope      <= trig_slope;
            // Port width already bounds pretrig_len to DEPTH-1.
            pre_len    <= pretrig_len;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            prev_valid <= 1'b0;
            triggered  <= 1'b0;
          end
          PRETRIG: begin
            if (sample_valid) fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == pre_len || (sample_valid && (fill_cnt + 1'b1) == pre_len))
              state <= ARMED;
          end
          ARMED: if (trig_hit) begin
            trig_addr <= wr_ptr;
            triggered <= 1'b1;
            post_cnt  <= (ADDR_W+1)'(1);
            state     <= POSTTRIG;
          end
          POSTTRIG: begin
            if (to_readout) begin
              state    <= READOUT;
              rd_cnt   <= '0;
              rd_valid <= 1'b1;
            end else if (sample_valid) begin
              post_cnt <= post_cnt + 1'b1;
            end
          end
          READOUT: if (xfer) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_last) begin
              rd_valid <= 1'b0;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scope_capture_trigger.sv
// Directed bench for scope_capture_trigger: stimulus pushes expected samples to a
// scoreboard queue, readout pops and compares.
module tb_scope_capture_trigger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_valid, arm, abort, force_trig, trig_slope, rd_ready;
  logic [7:0] sample_data, trig_level;
  logic [3:0] pretrig_len;
  logic       rd_valid, rd_last, busy, triggered, done;
  logic [7:0] rd_data;

  logic       sample_valid2, arm2, abort2, force_trig2, trig_slope2, rd_ready2;
  logic [7:0] sample_data2, trig_level2;
  logic [9:0] pretrig_len2;
  logic       rd_valid2, rd_last2, busy2, triggered2, done2;
  logic [7:0] rd_data2;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];
  logic [7:0] sb2 [$];

  always #5 clk = ~clk;

  scope_capture_trigger #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .arm(arm), .abort(abort), .force_trig(force_trig), .trig_level(trig_level),
    .trig_slope(trig_slope), .pretrig_len(pretrig_len), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .triggered(triggered), .done(done)
  );

  scope_capture_trigger #(.DATA_W(8), .ADDR_W(10)) dut2 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid2), .sample_data(sample_data2),
    .arm(arm2), .abort(abort2), .force_trig(force_trig2), .trig_level(trig_level2),
    .trig_slope(trig_slope2), .pretrig_len(pretrig_len2), .rd_valid(rd_valid2),
    .rd_ready(rd_ready2), .rd_data(rd_data2), .rd_last(rd_last2), .busy(busy2),
    .triggered(triggered2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v, input bit push, input bit frc);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = v;
    force_trig   = frc;
    if (push) sb.push_back(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_valid = 1'b0;
      force_trig   = 1'b0;
    end
  endtask

  task automatic arm_cap(input logic [7:0] lvl, input logic slp, input logic [3:0] pre);
    @(negedge clk);
    sample_valid = 1'b0;
    force_trig   = 1'b0;
    arm          = 1'b1;
    trig_level   = lvl;
    trig_slope   = slp;
    pretrig_len  = pre;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Ramp 0x00,0x10,... rising through 0x80 with 4 pre-trigger samples.
  task automatic rising_capture(input int gap);
    arm_cap(8'h80, 1'b0, 4'd4);
    for (int j = 0; j < 20; j++) begin
      send(8'(16 * j), j >= 4, 1'b0);
      if (gap > 0) idle(gap);
    end
    idle(1);
    #1;
    check("triggered_set", triggered, 1);
    check("busy_capture", busy, 1);
  endtask

  task automatic drain(input bit bp);
    int n = 0, cyc = 0, first = -1, vcnt = 0, done_seen = 0;
    bit stalled = 1'b0;
    logic [7:0] held = '0;
    logic [7:0] exp;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (n < 16 && cyc < 400) begin
      @(negedge clk);
      if (!bp)           rd_ready = 1'b1;
      else if (rd_valid) rd_ready = (vcnt < 4) ? pat[vcnt] : 1'($urandom_range(0, 1));
      else               rd_ready = 1'b0;
      #1;
      if (done) done_seen++;
      if (rd_valid) begin
        if (first < 0) first = cyc;
        vcnt++;
        if (stalled) check("hold_data", rd_data, held);
        check("rd_last", rd_last, n == 15);
        if (rd_ready) begin
          exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
          check("rd_data", rd_data, exp);
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = rd_data;
        end
      end
      cyc++;
    end
    check("xfer_count", n, 16);
    if (!bp) check("zero_bubble", cyc - first, 16);
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    check("done_pulses", done_seen, 1);
    check("idle_busy", busy, 0);
    check("idle_rd_valid", rd_valid, 0);
    check("triggered_held", triggered, 1);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    {sample_valid, arm, abort, force_trig, trig_slope, rd_ready} = '0;
    sample_data = '0; trig_level = '0; pretrig_len = '0;
    {sample_valid2, arm2, abort2, force_trig2, trig_slope2, rd_ready2} = '0;
    sample_data2 = '0; trig_level2 = '0; pretrig_len2 = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_busy", busy, 0);
    check("rst_triggered", triggered, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    // Rising edge, continuous samples.
    rising_capture(0);
    drain(1'b0);

    // Falling edge after the buffer has wrapped, with backpressure.
    arm_cap(8'h80, 1'b1, 4'd6);
    for (int j = 0; j < 40; j++) send(8'hF0, j >= 34, 1'b0);
    send(8'h20, 1'b1, 1'b0);
    for (int k = 1; k < 10; k++) send(8'(8'h20 + k), 1'b1, 1'b0);
    idle(1);
    drain(1'b1);

    // pretrig = 0, forced trigger on the first ARMED sample.
    arm_cap(8'h00, 1'b0, 4'd0);
    send(8'h55, 1'b1, 1'b1);
    for (int k = 1; k < 16; k++) send(8'(8'h60 + k), 1'b1, 1'b0);
    idle(1);
    drain(1'b0);

    // pretrig = 15: only the trigger sample is post-trigger; next sample dropped.
    arm_cap(8'h80, 1'b0, 4'd15);
    for (int j = 0; j < 20; j++) send(8'(j), j >= 5, 1'b0);
    send(8'h90, 1'b1, 1'b0);
    send(8'h91, 1'b0, 1'b0);
    idle(1);
    drain(1'b0);

    // Sample every third cycle: same content as the continuous case.
    rising_capture(2);
    drain(1'b0);

    // Abort during POSTTRIG.
    arm_cap(8'h80, 1'b0, 4'd4);
    for (int j = 0; j < 12; j++) send(8'(16 * j), 1'b0, 1'b0);
    idle(1);
    #1;
    check("pre_abort_trig", triggered, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_triggered", triggered, 0);
    check("abort_rd_valid", rd_valid, 0);

    // Abort wins over a simultaneous arm.
    @(negedge clk);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    #1;
    check("abort_over_arm", busy, 0);

    // Sync reset in the middle of readout.
    rising_capture(0);
    repeat (3) begin
      @(negedge clk);
      rd_ready = 1'b1;
    end
    @(negedge clk);
    rd_ready = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_valid", rd_valid, 0);
    check("rst_mid_triggered", triggered, 0);
    check("rst_mid_rd_last", rd_last, 0);
    sb.delete();

    rising_capture(0);
    drain(1'b0);

    // ADDR_W = 10 instance with the maximum pre-trigger length.
    @(negedge clk);
    arm2 = 1'b1; trig_level2 = 8'h80; trig_slope2 = 1'b0; pretrig_len2 = 10'h3FF;
    @(negedge clk);
    arm2 = 1'b0;
    for (int j = 0; j < 1023; j++) begin
      @(negedge clk);
      sample_valid2 = 1'b1;
      sample_data2  = 8'(j);
      sb2.push_back(8'(j));
    end
    @(negedge clk);
    sample_data2 = 8'hAA;
    force_trig2  = 1'b1;
    sb2.push_back(8'hAA);
    @(negedge clk);
    sample_valid2 = 1'b0;
    force_trig2   = 1'b0;
    #1;
    check("big_triggered", triggered2, 1);
    begin
      int n2 = 0, cyc2 = 0;
      logic [7:0] e2;
      while (n2 < 1024 && cyc2 < 1300) begin
        @(negedge clk);
        rd_ready2 = 1'b1;
        #1;
        if (rd_valid2) begin
          e2 = (sb2.size() > 0) ? sb2.pop_front() : 8'hxx;
          check("big_rd_data", rd_data2, e2);
          check("big_rd_last", rd_last2, n2 == 1023);
          n2++;
        end
        cyc2++;
      end
      check("big_xfer_count", n2, 1024);
    end
    @(negedge clk);
    rd_ready2 = 1'b0;
    #1;
    check("big_idle", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scope_capture_trigger.md
Name: scope_capture_trigger

Overview:
- Sits directly downstream of the AD9288 interface and consumes its 8-bit sample stream.
- Detects an edge trigger (level and slope programmable) and keeps a circular buffer with programmable pre-trigger depth.
- After capture, streams the DEPTH samples out in chronological order over a valid/ready port to the Ethernet/readout path.
- One capture per arm; no auto re-arm.

Parameters:
- DATA_W, 8, sample width.
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  DATA_W  ADC sample, unsigned.
- arm  in  1  single-cycle pulse; starts a capture when in IDLE.
- abort  in  1  returns to IDLE from any state; priority over arm.
- force_trig  in  1  treat the next accepted sample in ARMED as the trigger sample.
- trig_level  in  DATA_W  trigger threshold, sampled at arm.
- trig_slope  in  1  0 = rising, 1 = falling; sampled at arm.
- pretrig_len  in  ADDR_W  samples kept before the trigger; sampled at arm.
- rd_valid  out  1  rd_data holds a buffered sample.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  DATA_W  readout sample.
- rd_last  out  1  asserted with the DEPTH-th readout sample.
- busy  out  1  state != IDLE.
- triggered  out  1  trigger seen; held until the next arm or abort.
- done  out  1  one-cycle pulse when the last sample is accepted.

Behaviour:
- Reset (rst_n low at a clk edge): state = IDLE. All outputs 0: rd_valid, rd_data, rd_last, busy, triggered, done. Counters and prev-sample-valid flag cleared.
- IDLE -> PRETRIG on arm (ignored in any other state).
  - At arm: latch level, slope and pretrig_len. pretrig_len is clamped to DEPTH-1, so at least the trigger sample is post-trigger.
  - At arm: clear wr_ptr, fill count, prev_valid and triggered.
- PRETRIG: write each accepted sample at wr_ptr, then wr_ptr++ (mod DEPTH). Move to ARMED once fill count == latched pretrig_len. pretrig_len = 0 goes to ARMED on the next cycle. Trigger conditions are ignored in PRETRIG.
- ARMED: keep writing circularly (wrap-around overwrites the oldest data). An accepted sample triggers when any of these hold:
  - rising: prev_valid and prev < level and cur >= level;
  - falling: prev_valid and prev > level and cur <= level;
  - force_trig is high in the same cycle.
- On the trigger sample:
  - write the sample;
  - trig_addr = wr_ptr;
  - set triggered;
  - go to POSTTRIG with post count = 1.
- prev is updated with every accepted sample from arm onward; prev_valid is set after the first accepted sample.
- POSTTRIG: write accepted samples until post count == DEPTH - pretrig_len, then go to READOUT. Total stored = DEPTH; the trigger sample is at index pretrig_len in readout order.
- READOUT:
  - rd_ptr starts at (trig_addr - pretrig_len) mod DEPTH; emit DEPTH samples.
  - RAM read latency is 1 cycle; first rd_valid no later than 2 cycles after entering READOUT.
  - Transfer occurs when rd_valid && rd_ready. rd_data and rd_last must be stable while rd_valid && !rd_ready.
  - Zero-bubble throughput is required when rd_ready is held high.
  - After the transfer with rd_last, pulse done and go to IDLE. triggered stays 1 until the next arm.
- sample_valid low: no write, no counter advance, prev unchanged, in all states. Samples arriving during READOUT or IDLE are dropped.
- abort: next state IDLE; rd_valid, rd_last, triggered cleared; buffer contents undefined. abort and arm in the same cycle: abort wins.
- Counter/pointer arithmetic is ADDR_W-bit modulo; the post count uses ADDR_W+1 bits so the value DEPTH is representable.

Decomposition:
- Shared package scope_pkg: state enum (IDLE, PRETRIG, ARMED, POSTTRIG, READOUT) and constants SLOPE_RISING = 0, SLOPE_FALLING = 1.
- One sub-module scope_capture_ram: simple dual-port RAM, DEPTH x DATA_W, one write port, synchronous read with 1-cycle latency, inferable as block RAM.

Test Plan:
- Bench uses ADDR_W = 4 (DEPTH = 16) unless stated otherwise.
- Rising trigger: level = 0x80, pretrig = 4, ramp 0x00, 0x10, ... continuous -> trigger on 0x80; readout 16 samples 0x40..0x70, 0x80, ..., with 0x80 at index 4; rd_last on sample 16; done pulses once.
- Falling trigger with wrap: pretrig = 6, 40 samples at 0xF0, then 0x20 -> trigger at 0x20 after wrap; readout = six 0xF0 then 0x20 and post samples in order.
- Backpressure: rd_ready toggling 1-0-0-1 plus random -> no sample lost or duplicated; rd_data held while stalled; 16 transfers total.
- force_trig and boundaries:
  - pretrig = 0, force_trig on the first ARMED sample -> forced sample is readout index 0.
  - pretrig = 15 -> exactly 1 post sample.
  - pretrig = 0x3FF at ADDR_W = 10 -> clamped to 1023.
- sample_valid gaps: valid every 3rd cycle -> identical readout content to the continuous case.
- abort mid-POSTTRIG, then sync reset mid-READOUT -> IDLE, busy = 0, rd_valid = 0, triggered = 0 next cycle; a subsequent arm captures correctly.
